display_cmd_encoder: RTL and testbench

Command-word transmitter for the sprite display peripherals. It accepts per-object update requests from the game-logic side through a valid/ready handshake and buffers them in a small FIFO. Each request is serialized into the 32-bit command words that the display blocks decode from `writedata`. At frame end it issues the ping-pong buffer-swap command and tracks which buffer is front, so every update lands in the back buffer.

---
 rtl/display_cmd_encoder.sv | 188 ++++++++++++++++++
 tb/tb_display_cmd_encoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_cmd_encoder.sv
// Sprite display command-word transmitter.
// Buffers object updates, serializes them to 4 words, and issues buffer swaps.
module display_cmd_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_component,
  input  logic [4:0]  req_child,
  input  logic        req_visible,
  input  logic        req_flip,
  input  logic [4:0]  req_pattern,
  input  logic [9:0]  req_x,
  input  logic [9:0]  req_y,
  input  logic [9:0]  req_attr,
  input  logic        frame_end,
  output logic [31:0] writedata,
  output logic        cmd_valid,
  output logic        front_buf
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [5:0] comp;
    logic [4:0] child;
    logic       visible;
    logic       flip;
    logic [4:0] pattern;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] attr;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    W1,
    W2,
    W3
  } state_t;

  localparam logic [3:0] ACT_UPD  = 4'b0001;
  localparam logic [3:0] ACT_SWAP = 4'b1111;

  function automatic logic [31:0] mk(
    input logic [5:0]  c,
    input logic [4:0]  ch,
    input logic [3:0]  act,
    input logic [2:0]  ty,
    input logic        tg,
    input logic [12:0] d
  );
    return {c, ch, act, ty, tg, d};
  endfunction

  req_t          mem [FIFO_DEPTH];
  req_t          cur;
  req_t          head;
  req_t          in_req;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  state_t        state;
  state_t        state_n;
  logic [31:0]   word_n;
  logic          valid_n;
  logic          swap_load;
  logic          swap_pending;
  logic          tg;

  assign in_req = '{
    comp:    req_component,
    child:   req_child,
    visible: req_visible,
    flip:    req_flip,
    pattern: req_pattern,
    x:       req_x,
    y:       req_y,
    attr:    req_attr
  };

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign req_ready = !full && !reset;
  assign push      = req_valid && req_ready;
  assign head      = mem[rptr];
  assign tg        = ~front_buf;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= in_req;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      cur <= head;
    end
  end

  always_comb begin
    state_n   = state;
    word_n    = '0;
    valid_n   = 1'b0;
    pop       = 1'b0;
    swap_load = 1'b0;
    unique case (state)
      IDLE: begin
        // Swap wins over queued work so it lands between sequences
        if (swap_pending) begin
          swap_load = 1'b1;
          valid_n   = 1'b1;
          word_n    = mk(6'd0, 5'd0, ACT_SWAP, 3'd0, tg, 13'd0);
        end else if (!empty) begin
          pop     = 1'b1;
          valid_n = 1'b1;
          state_n = W1;
          word_n  = mk(head.comp, head.child, ACT_UPD, 3'd1, tg,
                       {head.visible, head.flip, 6'd0, head.pattern});
        end
      end
      W1: begin
        valid_n = 1'b1;
        state_n = W2;
        word_n  = mk(cur.comp, cur.child, ACT_UPD, 3'd2, tg,
                     {3'd0, cur.x});
      end
      W2: begin
        valid_n = 1'b1;
        state_n = W3;
        word_n  = mk(cur.comp, cur.child, ACT_UPD, 3'd3, tg,
                     {3'd0, cur.y});
      end
      W3: begin
        valid_n = 1'b1;
        state_n = IDLE;
        word_n  = mk(cur.comp, cur.child, ACT_UPD, 3'd4, tg,
                     {3'd0, cur.attr});
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      writedata    <= '0;
      cmd_valid    <= 1'b0;
      front_buf    <= 1'b0;
      swap_pending <= 1'b0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
    end else begin
      state     <= state_n;
      writedata <= word_n;
      cmd_valid <= valid_n;
      if (swap_load) begin
        front_buf <= ~front_buf;
      end
      // A frame_end coinciding with the swap load is absorbed
      if (swap_load) begin
        swap_pending <= 1'b0;
      end else if (frame_end) begin
        swap_pending <= 1'b1;
      end
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_display_cmd_encoder.sv
// Directed self-checking bench for display_cmd_encoder.
// Hand-computed word vectors plus a FIFO fill/ordering run.
module tb_display_cmd_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_component;
  logic [4:0]  req_child;
  logic        req_visible;
  logic        req_flip;
  logic [4:0]  req_pattern;
  logic [9:0]  req_x;
  logic [9:0]  req_y;
  logic [9:0]  req_attr;
  logic        frame_end;
  logic [31:0] writedata;
  logic        cmd_valid;
  logic        front_buf;

  int checks = 0;
  int errors = 0;

  display_cmd_encoder #(.FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_component (req_component),
    .req_child     (req_child),
    .req_visible   (req_visible),
    .req_flip      (req_flip),
    .req_pattern   (req_pattern),
    .req_x         (req_x),
    .req_y         (req_y),
    .req_attr      (req_attr),
    .frame_end     (frame_end),
    .writedata     (writedata),
    .cmd_valid     (cmd_valid),
    .front_buf     (front_buf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] w);
    chk({tag, "_data"}, writedata, w);
    chk({tag, "_valid"}, {31'd0, cmd_valid}, 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_data"}, writedata, 32'd0);
    chk({tag, "_valid"}, {31'd0, cmd_valid}, 32'd0);
  endtask

  task automatic set_req(input logic [5:0] c, input logic [4:0] ch,
                         input logic v, input logic f,
                         input logic [4:0] p, input logic [9:0] x,
                         input logic [9:0] y, input logic [9:0] a);
    req_component = c;
    req_child     = ch;
    req_visible   = v;
    req_flip      = f;
    req_pattern   = p;
    req_x         = x;
    req_y         = y;
    req_attr      = a;
  endtask

  function automatic logic [31:0] ew(input int i, input logic [2:0] ty);
    logic [5:0]  c;
    logic [4:0]  ch;
    logic [12:0] d;
    c  = 6'(i + 1);
    ch = 5'(i + 8);
    unique case (ty)
      3'd1:    d = {i[0], ~i[0], 6'd0, 5'(i + 3)};
      3'd2:    d = {3'd0, 10'(100 + i)};
      3'd3:    d = {3'd0, 10'(500 + i)};
      default: d = {3'd0, 10'(900 + i)};
    endcase
    return {c, ch, 4'b0001, ty, 1'b1, d};
  endfunction

  initial begin
    logic [31:0] q[$];
    logic        rdy;
    logic        saw_low;
    logic        seen;
    int          k;
    int          got;
    logic [31:0] e;

    reset     = 1'b1;
    req_valid = 1'b0;
    frame_end = 1'b0;
    set_req(6'd0, 5'd0, 1'b0, 1'b0, 5'd0, 10'd0, 10'd0, 10'd0);
    step();
    step();
    chk_idle("rst");
    chk("rst_front", {31'd0, front_buf}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // basic request, toggle = 1
    set_req(6'd2, 5'd3, 1'b1, 1'b0, 5'd5, 10'd100, 10'd200, 10'd0);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk_idle("a_lat");
    step(); chk_word("a_w1", 32'h0862_7005);
    step(); chk_word("a_x",  32'h0862_A064);
    step(); chk_word("a_y",  32'h0862_E0C8);
    step(); chk_word("a_at", 32'h0863_2000);
    step(); chk_idle("a_end");

    // swap from idle
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    chk_idle("sw_lat");
    step();
    chk_word("sw", 32'h001E_2000);
    chk("sw_front", {31'd0, front_buf}, 32'd1);
    step(); chk_idle("sw_end");

    // request after swap carries toggle = 0
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step(); chk_word("b_w1", 32'h0862_5005);
    step(); chk_word("b_x",  32'h0862_8064);
    step(); chk_word("b_y",  32'h0862_C0C8);
    step(); chk_word("b_at", 32'h0863_0000);
    step(); chk_idle("b_end");

    // unfiltered fields, frame_end twice mid-sequence
    set_req(6'd2, 5'd20, 1'b0, 1'b1, 5'd30, 10'd1023, 10'd0, 10'h155);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step(); chk_word("c_w1", 32'h0A82_481E);
    frame_end = 1'b1;
    step(); chk_word("c_x",  32'h0A82_83FF);
    frame_end = 1'b0;
    step(); chk_word("c_y",  32'h0A82_C000);
    frame_end = 1'b1;
    step(); chk_word("c_at", 32'h0A83_0155);
    frame_end = 1'b0;
    step();
    chk_word("c_sw", 32'h001E_0000);
    chk("c_front", {31'd0, front_buf}, 32'd0);
    step(); chk_idle("c_one_swap");
    step(); chk_idle("c_one_swap2");

    // fill FIFO with 6 requests, valid held high
    k       = 0;
    got     = 0;
    saw_low = 1'b0;
    seen    = 1'b0;
    for (int cyc = 0; cyc < 80 && got < 24; cyc++) begin
      if (k < 6) begin
        set_req(6'(k + 1), 5'(k + 8), k[0], ~k[0], 5'(k + 3),
                10'(100 + k), 10'(500 + k), 10'(900 + k));
        req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      #1;
      rdy = req_ready;
      if (!rdy) saw_low = 1'b1;
      step();
      if (cmd_valid) begin
        seen = 1'b1;
        got++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL fill_extra observed=%h expected=none", writedata);
        end else begin
          e = q.pop_front();
          chk("fill_word", writedata, e);
        end
      end else if (seen) begin
        checks++;
        errors++;
        $error("FAIL fill_gap observed=0 expected=1 at word %0d", got);
      end
      if (rdy && req_valid) begin
        for (int t = 1; t <= 4; t++) q.push_back(ew(k, 3'(t)));
        k++;
      end
    end
    req_valid = 1'b0;
    chk("fill_accepted", 32'(k), 32'd6);
    chk("fill_words", 32'(got), 32'd24);
    chk("fill_ready_low", {31'd0, saw_low}, 32'd1);
    chk("fill_q_empty", 32'(q.size()), 32'd0);
    step(); chk_idle("fill_end");

    // reset during W2
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    step();
    chk_word("r_sw", 32'h001E_2000);
    chk("r_front1", {31'd0, front_buf}, 32'd1);
    set_req(6'd2, 5'd3, 1'b1, 1'b0, 5'd5, 10'd100, 10'd200, 10'd0);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step(); chk_word("r_w1", 32'h0862_5005);
    step(); chk_word("r_x",  32'h0862_8064);
    reset = 1'b1;
    step();
    chk_idle("r_rst");
    chk("r_front0", {31'd0, front_buf}, 32'd0);
    chk("r_ready0", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("r_ready1", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_idle("r_no_resume");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
